// File: rtl/tref_leak_scheduler.sv
// Leak-tick scheduler: acknowledges a pending Tref flag, then issues one leak
// request per neuron address over valid/ready, yielding new requests to spike traffic.
module tref_leak_scheduler #(
  parameter int N_NEURON = 256,
  parameter int ADDR_W   = 8,
  parameter int OVR_W    = 8,
  parameter int TICK_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Tref_Event_In,
  output logic              Receive_Tref,
  input  logic              Spike_Busy,
  output logic              Leak_Valid,
  input  logic              Leak_Ready,
  output logic [ADDR_W-1:0] Leak_Addr,
  output logic              Leak_Last,
  output logic              Scan_Active,
  output logic [OVR_W-1:0]  Overrun_Cnt,
  output logic [TICK_W-1:0] Tick_Cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEURON - 1);
  localparam logic [OVR_W-1:0]  OVR_MAX   = {OVR_W{1'b1}};

  state_t              r_state;
  state_t              w_next_state;
  logic                r_ack;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_last;
  logic                r_active;
  logic [OVR_W-1:0]    r_ovr;
  logic [TICK_W-1:0]   r_tick;
  logic                r_ovr_prev;

  logic                w_ack_nxt;
  logic                w_valid_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_last_nxt;
  logic                w_active_nxt;
  logic [OVR_W-1:0]    w_ovr_nxt;
  logic [TICK_W-1:0]   w_tick_nxt;
  logic                w_ovr_cond;
  logic                w_xfer;
  logic                w_at_last;

  assign w_xfer     = (r_state == ST_SCAN) && r_valid && Leak_Ready;
  assign w_at_last  = (r_addr == LAST_ADDR);
  // A tick still pending while scanning counts once per rising edge of this condition
  assign w_ovr_cond = ((r_state == ST_SCAN) || (r_state == ST_DONE)) && Tref_Event_In;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_valid    <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_last     <= 1'b0;
      r_active   <= 1'b0;
      r_ovr      <= {OVR_W{1'b0}};
      r_tick     <= {TICK_W{1'b0}};
      r_ovr_prev <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ack      <= w_ack_nxt;
      r_valid    <= w_valid_nxt;
      r_addr     <= w_addr_nxt;
      r_last     <= w_last_nxt;
      r_active   <= w_active_nxt;
      r_ovr      <= w_ovr_nxt;
      r_tick     <= w_tick_nxt;
      r_ovr_prev <= w_ovr_cond;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Tref_Event_In) w_next_state = ST_ACK;
        else               w_next_state = ST_IDLE;
      end
      ST_ACK:  w_next_state = ST_SCAN;
      ST_SCAN: begin
        if (w_xfer && w_at_last) w_next_state = ST_DONE;
        else                     w_next_state = ST_SCAN;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt   = 1'b0;
    w_valid_nxt = r_valid;
    w_addr_nxt  = r_addr;
    w_tick_nxt  = r_tick;
    case (r_state)
      ST_IDLE: begin
        w_ack_nxt   = Tref_Event_In;
        w_valid_nxt = 1'b0;
      end
      ST_ACK: begin
        w_addr_nxt  = {ADDR_W{1'b0}};
        w_valid_nxt = ~Spike_Busy;
      end
      ST_SCAN: begin
        // Once raised, a request is held until accepted regardless of Spike_Busy
        if (r_valid) begin
          if (Leak_Ready) begin
            if (w_at_last) begin
              w_valid_nxt = 1'b0;
            end else begin
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_valid_nxt = ~Spike_Busy;
            end
          end else begin
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_valid_nxt = ~Spike_Busy;
        end
      end
      ST_DONE: begin
        w_valid_nxt = 1'b0;
        w_tick_nxt  = r_tick + TICK_W'(1);
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase

    w_last_nxt   = w_valid_nxt && (w_addr_nxt == LAST_ADDR);
    w_active_nxt = (w_next_state != ST_IDLE);

    if (w_ovr_cond && !r_ovr_prev && (r_ovr != OVR_MAX)) begin
      w_ovr_nxt = r_ovr + OVR_W'(1);
    end else begin
      w_ovr_nxt = r_ovr;
    end
  end

  assign Receive_Tref = r_ack;
  assign Leak_Valid   = r_valid;
  assign Leak_Addr    = r_addr;
  assign Leak_Last    = r_last;
  assign Scan_Active  = r_active;
  assign Overrun_Cnt  = r_ovr;
  assign Tick_Cnt     = r_tick;

endmodule

// File: tb/tb_tref_leak_scheduler.sv
// Self-checking bench for tref_leak_scheduler: directed scenarios plus random traffic,
// compared every cycle against a scan-level behavioural model and an upstream flag model.
module tb_tref_leak_scheduler;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int OW = 2;
  localparam int TW = 4;
  localparam int OVR_MAX = (1 << OW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Tref_Event_In = 1'b0;
  logic          Spike_Busy = 1'b0;
  logic          Leak_Ready = 1'b1;
  logic          Receive_Tref;
  logic          Leak_Valid;
  logic [AW-1:0] Leak_Addr;
  logic          Leak_Last;
  logic          Scan_Active;
  logic [OW-1:0] Overrun_Cnt;
  logic [TW-1:0] Tick_Cnt;

  always #5 CLK = ~CLK;

  tref_leak_scheduler #(.N_NEURON(N), .ADDR_W(AW), .OVR_W(OW), .TICK_W(TW)) dut (
    .CLK(CLK), .RST(RST), .Tref_Event_In(Tref_Event_In), .Receive_Tref(Receive_Tref),
    .Spike_Busy(Spike_Busy), .Leak_Valid(Leak_Valid), .Leak_Ready(Leak_Ready),
    .Leak_Addr(Leak_Addr), .Leak_Last(Leak_Last), .Scan_Active(Scan_Active),
    .Overrun_Cnt(Overrun_Cnt), .Tick_Cnt(Tick_Cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: one scan = ack cycle, N accepted addresses, one completion cycle
  bit m_in_scan, m_ack, m_valid, m_last, m_active, m_prev;
  int m_addr, m_left, m_ovr, m_tick;

  task automatic model_reset();
    m_in_scan = 0; m_ack = 0; m_valid = 0; m_last = 0; m_active = 0; m_prev = 0;
    m_addr = 0; m_left = 0; m_ovr = 0; m_tick = 0;
  endtask

  task automatic model_advance(input bit f, input bit b, input bit r);
    bit cond;
    cond = m_in_scan && !m_ack && f;
    if (cond && !m_prev && m_ovr < OVR_MAX) m_ovr++;
    m_prev = cond;
    if (!m_in_scan) begin
      if (f) begin
        m_in_scan = 1; m_ack = 1; m_left = N;
      end
      m_valid = 0;
    end else if (m_ack) begin
      m_ack = 0; m_addr = 0; m_valid = !b;
    end else if (m_left > 0) begin
      if (m_valid && r) begin
        m_left--;
        if (m_left == 0) m_valid = 0;
        else begin
          m_addr++; m_valid = !b;
        end
      end else if (!m_valid) begin
        m_valid = !b;
      end
    end else begin
      m_tick = (m_tick + 1) % (1 << TW);
      m_in_scan = 0;
    end
    m_last   = m_valid && (m_addr == N - 1);
    m_active = m_in_scan;
  endtask

  // Observed outputs of the current cycle, upstream flag state, DUT transfer log
  bit            o_ack, o_valid, o_last, o_active;
  int            o_addr, o_ovr, o_tick;
  bit            flag = 0;
  bit            ack_prev = 0;
  bit            prev_active = 0;
  bit            prev_rst = 1;
  int            cyc = 0;
  int            ack_cnt = 0;
  int            xfer_cnt = 0;
  int            dut_log[$];

  task automatic step(input bit set_req, input bit busy, input bit ready, input bit rst);
    bit ok;
    @(negedge CLK);
    o_ack = Receive_Tref; o_valid = Leak_Valid; o_last = Leak_Last; o_active = Scan_Active;
    o_addr = int'(Leak_Addr); o_ovr = int'(Overrun_Cnt); o_tick = int'(Tick_Cnt);
    check($sformatf("cycle %0d outputs {ack,valid,last,active,addr,ovr,tick}", cyc),
          {50'd0, Receive_Tref, Leak_Valid, Leak_Last, Scan_Active, Leak_Addr, Overrun_Cnt, Tick_Cnt},
          {50'd0, m_ack, m_valid, m_last, m_active, AW'(m_addr), OW'(m_ovr), TW'(m_tick)});
    ack_cnt += int'(o_ack);
    if (prev_active && !o_active && !prev_rst) begin
      ok = (dut_log.size() == N);
      foreach (dut_log[i]) if (dut_log[i] != i) ok = 0;
      check($sformatf("cycle %0d scan address order (count %0d)", cyc, dut_log.size()), ok, 1'b1);
      dut_log.delete();
    end
    prev_active = o_active;
    flag = set_req | (flag & ~ack_prev);
    ack_prev = o_ack;
    Tref_Event_In = flag; Spike_Busy = busy; Leak_Ready = ready; RST = rst;
    if (rst) dut_log.delete();
    else if (o_valid && ready) begin
      dut_log.push_back(o_addr);
      xfer_cnt++;
    end
    prev_rst = rst;
    if (rst) model_reset();
    else model_advance(flag, busy, ready);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  int tick0, ovr0, xfer0;

  initial begin
    model_reset();
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    check("reset outputs all zero",
          {o_ack, o_valid, o_last, o_active, 3'(o_addr), 2'(o_ovr), 4'(o_tick)}, 13'd0);
    idle(3);

    // 1: single tick, literal timing of ack, addresses, last, completion
    tick0 = o_tick; ack_cnt = 0;
    step(1, 0, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 1, 0);
      check($sformatf("s1 k=%0d ack", k), o_ack, (k == 1));
      check($sformatf("s1 k=%0d valid", k), o_valid, (k >= 2 && k <= 9));
      if (o_valid) check($sformatf("s1 k=%0d addr", k), o_addr, k - 2);
      check($sformatf("s1 k=%0d last", k), o_last, (k == 9));
      check($sformatf("s1 k=%0d active", k), o_active, (k <= 10));
    end
    check("s1 tick count", o_tick, (tick0 + 1) % 16);
    check("s1 ack pulses", ack_cnt, 1);

    // 2: ready low 3 cycles while addr 3 is offered, busy pulsed meanwhile
    xfer0 = xfer_cnt;
    step(1, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, (k == 6 || k == 7), !(k >= 5 && k <= 7), 0);
      if (k >= 5 && k <= 8)
        check($sformatf("s2 k=%0d held addr3", k), {o_valid, 3'(o_addr)}, {1'b1, 3'd3});
    end
    check("s2 transfers", xfer_cnt - xfer0, N);

    // 3: spike path busy right after the tick, scan must still complete from 0
    tick0 = o_tick;
    step(1, 0, 1, 0);
    for (int k = 1; k <= 20; k++) step(0, (k >= 1 && k <= 5), 1, 0);
    check("s3 tick count", o_tick, (tick0 + 1) % 16);

    // 4: new tick raised mid-scan at addr 4
    tick0 = o_tick; ovr0 = o_ovr; ack_cnt = 0;
    step(1, 0, 1, 0);
    for (int k = 1; k <= 28; k++) step((k == 6), 0, 1, 0);
    check("s4 overrun", o_ovr, ovr0 + 1);
    check("s4 tick count", o_tick, (tick0 + 2) % 16);
    check("s4 ack pulses", ack_cnt, 2);

    // 5: upstream set coincides with ack clear, flag stays high into the scan
    ovr0 = o_ovr; ack_cnt = 0;
    step(1, 0, 1, 0);
    for (int k = 1; k <= 28; k++) begin
      step((k == 2), 0, 1, 0);
      if (k == 3) check("s5 overrun after first scan cycle", o_ovr, ovr0 + 1);
    end
    check("s5 ack pulses", ack_cnt, 2);
    check("s5 overrun final", o_ovr, ovr0 + 1);

    // 6: reset at addr 5 with the flag re-raised
    step(1, 0, 1, 0);
    for (int k = 1; k <= 6; k++) step(0, 0, 1, 0);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    check("s6 outputs in reset",
          {o_ack, o_valid, o_last, o_active, 3'(o_addr), 2'(o_ovr), 4'(o_tick)}, 13'd0);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 0);
    check("s6 tick after reset scan", o_tick, 1);

    // Overrun saturation
    for (int rep = 0; rep < 5; rep++) begin
      step(1, 0, 1, 0);
      for (int k = 1; k <= 26; k++) step((k == 5), 0, 1, 0);
    end
    check("overrun saturated", o_ovr, OVR_MAX);

    // Random traffic
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    idle(40);
    check("final idle", o_active, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
